// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider (one quotient bit per cycle)
// serving the EX stage. Returns {remainder, quotient} with ready_o and honours
// an annul from EX while a division is in flight.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Two's-complement negation modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  div_state_t  state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [64:0] work_r, work_s;
  logic [31:0] divisor_r, divisor_s;
  logic        neg_quot_r, neg_quot_s;
  logic        neg_rem_r, neg_rem_s;
  logic [63:0] result_r, result_s;
  logic        ready_r, ready_s;

  logic [32:0] trial_s;
  logic [31:0] dividend_mag_s;
  logic [31:0] divisor_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  assign result_o = result_r;
  assign ready_o  = ready_r;

  // Next-state, datapath and output computation for the divider FSM.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    work_s     = work_r;
    divisor_s  = divisor_r;
    neg_quot_s = neg_quot_r;
    neg_rem_s  = neg_rem_r;
    result_s   = result_r;
    ready_s    = ready_r;

    // Operand magnitudes; unsigned operands are taken as-is.
    dividend_mag_s = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
    divisor_mag_s  = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;

    // 33-bit trial subtraction: a set top bit means the divisor did not fit.
    trial_s = work_r[64:32] - {1'b0, divisor_r};
    quot_s  = neg_quot_r ? neg32(work_r[31:0])  : work_r[31:0];
    rem_s   = neg_rem_r  ? neg32(work_r[64:33]) : work_r[64:33];

    case (state_r)
      DIV_FREE: begin
        ready_s  = 1'b0;
        result_s = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_s = DIV_BY_ZERO;
          end else begin
            state_s    = DIV_ON;
            cnt_s      = 6'd0;
            work_s     = {32'd0, dividend_mag_s, 1'b0};
            divisor_s  = divisor_mag_s;
            neg_quot_s = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_s  = signed_div_i & opdata1_i[31];
          end
        end else begin
          state_s = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        state_s  = DIV_END;
        result_s = 64'd0;
        ready_s  = 1'b1;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_s = DIV_FREE;
          cnt_s   = 6'd0;
          ready_s = 1'b0;
        end else if (cnt_r < 6'd32) begin
          if (!trial_s[32]) begin
            work_s = {trial_s[31:0], work_r[31:0], 1'b1};
          end else begin
            work_s = {work_r[63:0], 1'b0};
          end
          cnt_s = cnt_r + 6'd1;
        end else begin
          result_s = {rem_s, quot_s};
          ready_s  = 1'b1;
          state_s  = DIV_END;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          state_s  = DIV_FREE;
          ready_s  = 1'b0;
          result_s = 64'd0;
        end else begin
          state_s = DIV_END;
        end
      end
      default: begin
        state_s  = DIV_FREE;
        cnt_s    = 6'd0;
        ready_s  = 1'b0;
        result_s = 64'd0;
      end
    endcase
  end

  // State and datapath registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= DIV_FREE;
      cnt_r      <= 6'd0;
      work_r     <= 65'd0;
      divisor_r  <= 32'd0;
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_r   <= 64'd0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      work_r     <= work_s;
      divisor_r  <= divisor_s;
      neg_quot_r <= neg_quot_s;
      neg_rem_r  <= neg_rem_s;
      result_r   <= result_s;
      ready_r    <= ready_s;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected {remainder, quotient}
// and latency are queued when a request is driven and compared when ready_o rises.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference quotient/remainder from operand magnitudes.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (sg && a[31]) ? (32'd0 - a) : a;
    mb = (sg && b[31]) ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sg && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sg && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Drive a request, scramble operands after sampling, wait for ready_o, compare.
  task automatic issue(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    int   n;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_q.push_back('{exp_res, exp_lat});
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_lat"}, 64'(n), 64'(e.lat));
      check_eq({tag, "_res"}, result_o, e.res);
    end
  endtask

  // Drop start and confirm ready/result clear after the next edge.
  task automatic release_start(input string tag);
    @(negedge clk);
    check_eq({tag, "_held"}, {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_rdy_off"}, {63'd0, ready_o}, 64'd0);
    check_eq({tag, "_res_off"}, result_o, 64'd0);
  endtask

  initial begin
    logic        seen_rdy;
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rs;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("reset_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    issue("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    release_start("u100_7");
    issue("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    release_start("s_m7_2");
    issue("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 33);
    release_start("u_m7_2");
    issue("div0", 1'b0, 32'h12345678, 32'd0, 64'd0, 1);
    release_start("div0");
    issue("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    release_start("s_ovf");

    // Annul while cnt==10: sampling edge plus ten iterations, then annul.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    seen_rdy     = 1'b0;
    repeat (11) begin
      @(posedge clk);
      #1;
      seen_rdy = seen_rdy | ready_o;
    end
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    seen_rdy = seen_rdy | ready_o;
    annul_i  = 1'b0;
    check_eq("annul_no_rdy", {63'd0, seen_rdy}, 64'd0);
    issue("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
    release_start("after_annul");

    // Reset in the middle of an iteration, between edges.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd77;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_on_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("rst_on_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset while a result is being presented clears it immediately.
    issue("u_ffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_end_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue("post_rst", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);
    release_start("post_rst");

    // Start with annul in DIV_FREE must never launch a division.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    seen_rdy     = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_rdy = seen_rdy | ready_o;
    end
    check_eq("start_annul_free", {63'd0, seen_rdy}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;

    // Annul in DIV_END is ignored while start stays high.
    issue("end_annul", 1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33);
    held = result_o;
    @(negedge clk);
    annul_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("end_annul_rdy", {63'd0, ready_o}, 64'd1);
    check_eq("end_annul_res", result_o, held);
    @(negedge clk);
    annul_i = 1'b0;
    release_start("end_annul");

    // Random operands in both modes against the reference model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd1 : ((i == 5) ? 32'hFFFFFFFF : ($urandom >> (i * 3)));
      rs = i[0];
      issue($sformatf("rnd%0d", i), rs, ra, rb, model(rs, ra, rb), (rb == 32'd0) ? 1 : 33);
      release_start($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving as the responder to the EX stage's division request. EX raises a start request with two operands and holds its stall request to ctrl until this block returns ready with the 64-bit {remainder, quotient} result, which EX then forwards as the HI/LO write. The block implements restoring division at one quotient bit per cycle and accepts an annul from EX to abandon a division in flight.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state and outputs immediately.
- signed_div_i  in  1  1 = signed (DIV) operation, 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  32  dividend; sampled with start_i.
- opdata2_i  in  32  divisor; sampled with start_i.
- start_i  in  1  request; held high by EX until the cycle after ready_o is seen.
- annul_i  in  1  abort request; has priority over start_i.
- result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
- ready_o  out  1  result valid.

## Operation
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. Internal: 65-bit working register (remainder/quotient shift pair), 6-bit counter cnt, latched divisor magnitude, latched sign flags.
- DIV_FREE: ready_o=0, result_o=0. On edge with start_i=1 and annul_i=0:
  - divisor==0 -> DIV_BY_ZERO.
  - else -> DIV_ON, cnt=0, working register = {32'b0, |dividend|, 1'b0} when signed (two's-complement magnitude), raw dividend when unsigned; divisor magnitude latched likewise; sign flags latched.
  - start_i with annul_i=1: stay in DIV_FREE.
- DIV_BY_ZERO: next edge -> DIV_END with result = 64'b0.
- DIV_ON, annul_i=1 -> DIV_FREE, cnt=0, ready_o stays 0.
- DIV_ON, cnt<32: trial = working[64:32] - {1'b0, divisor}; if no borrow, working = {trial[31:0], working[31:0], 1'b1}, else working = {working[63:0], 1'b0}; cnt++.
- DIV_ON, cnt==32: quotient = working[31:0], remainder = working[64:33]. Signed mode: negate quotient if dividend and divisor signs differ; negate remainder if dividend negative. Register result_o, ready_o=1, -> DIV_END.
- DIV_END: ready_o=1, result_o held. Edge with start_i=0 -> DIV_FREE, ready_o=0, result_o=0. While start_i stays high the block remains in DIV_END.
- Arithmetic: all results modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, no exception. Unsigned operands never negated. Operand changes after the sampling edge have no effect.

## Timing
- Reset (rst=0, async): state DIV_FREE, cnt=0, ready_o=0, result_o=0, working register 0. Reset mid-division discards it; first post-reset start behaves normally.
- Normal latency: sampling edge E0 -> DIV_ON; iterations on edges E1..E32; ready_o=1 and result_o valid after E33 (registered outputs, no combinational input->output path).
- Divide by zero: E0 -> DIV_BY_ZERO, E1 -> DIV_END, ready_o=1 after E1.
- ready_o stays high for at least one cycle and until start_i is low at an edge; it drops after that edge. A new start is accepted no earlier than the edge after return to DIV_FREE.
- annul_i in DIV_END or DIV_BY_ZERO is ignored; only start_i deassertion leaves DIV_END.

## Test plan
- Unsigned 100 / 7, start held: ready_o rises exactly 33 edges after sampling edge, result_o = 0x00000002_0000000E; deassert start -> next edge ready_o=0, result_o=0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD; same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divisor 0 (0x12345678 / 0): ready_o after 2 edges, result_o = 0; signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
- Annul at cnt=10 -> DIV_FREE next edge, ready_o never asserts; immediate new start 9 / 3 -> result_o = 0x00000000_00000003 after 33 edges.
- Assert rst low mid-DIV_ON (between edges) -> ready_o and result_o 0 immediately; after release, 0xFFFFFFFF / 0x10 unsigned -> 0x0000000F_0FFFFFFF.
- Start and annul asserted together in DIV_FREE -> no state change; annul during DIV_END -> result held, ready_o stays 1.
